gat_host_bram_bridge: RTL and testbench

- Parametrised host-to-accelerator BRAM bridge that sits between the AXI BRAM controllers / register bank and the GAT core.
- Converts 32-bit byte-addressed host beats into native-width BRAM words for NUM_CH load channels, packing up to 8 beats per word for words wider than 32 bits.
- Tracks load completion and error status per channel, and generates a one-shot core start.
- Provides a latency-matched feature readback path with a valid strobe.

---
 rtl/gat_bridge_pkg.sv | 33 +++
 rtl/gat_bram_beat_packer.sv | 140 ++++++++++++++
 rtl/gat_host_bram_bridge.sv | 128 ++++++++++++
 tb/tb_gat_host_bram_bridge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gat_bridge_pkg.sv
// Shared constants and elaboration-time helpers for the host-to-GAT BRAM bridge.
// Provides the ceil-log2 and beats-per-word helpers, status-word field offsets
// and the channel index assignments used by the bridge and its packers.
package gat_bridge_pkg;

  // Channel index assignments
  localparam int unsigned CH_HDATA = 0;
  localparam int unsigned CH_NODE  = 1;
  localparam int unsigned CH_WGT   = 2;
  localparam int unsigned CH_SUBG  = 3;

  // Status word layout: {err_oob, err_partial, done, word_count[28:0]}
  localparam int unsigned ST_COUNT_W     = 29;
  localparam int unsigned ST_DONE_BIT    = 29;
  localparam int unsigned ST_PARTIAL_BIT = 30;
  localparam int unsigned ST_OOB_BIT     = 31;

  // Smallest r with 2^r >= v (log2_f(1) == 0)
  function automatic int unsigned log2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // 32-bit host beats per native word, rounded up to a power of two
  function automatic int unsigned beats_f(input int unsigned width);
    return 32'd1 << log2_f((width + 31) / 32);
  endfunction

endpackage

// File: rtl/gat_bram_beat_packer.sv
// One load channel of the host BRAM bridge.
// Collects 32-bit host beats into a shadow word, issues a single BRAM write
// one cycle after the final slot is written, counts issued words and keeps
// sticky out-of-bounds / partial-word / done status.
// Ports:
//   clk, rst, soft_clr        clock, async reset, synchronous clear
//   din, en, we, addr         host beat (byte address)
//   load_done                 level load-done bit from the register bank
//   bram_we/bram_addr/bram_din  write strobe, word address, zero-extended word
//   done, err_oob, err_partial, word_count  channel status
module gat_bram_beat_packer
  import gat_bridge_pkg::*;
#(
  parameter int unsigned TOP_WIDTH  = 32,
  parameter int unsigned MAX_DATA_W = 128,
  parameter int unsigned MAX_ADDR_W = 18,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 13264
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    soft_clr,
  input  logic [TOP_WIDTH-1:0]    din,
  input  logic                    en,
  input  logic                    we,
  input  logic [MAX_ADDR_W+4:0]   addr,
  input  logic                    load_done,
  output logic                    bram_we,
  output logic [MAX_ADDR_W-1:0]   bram_addr,
  output logic [MAX_DATA_W-1:0]   bram_din,
  output logic                    done,
  output logic                    err_oob,
  output logic                    err_partial,
  output logic [ST_COUNT_W-1:0]   word_count
);

  localparam int unsigned BEATS  = beats_f(DATA_W);
  localparam int unsigned LOG_B  = log2_f(BEATS);
  localparam int unsigned SLOT_W = (LOG_B == 0) ? 1 : LOG_B;
  localparam int unsigned FLAT_W = BEATS * TOP_WIDTH;
  localparam logic [MAX_ADDR_W+4:0] DEPTH_V = (MAX_ADDR_W + 5)'(DEPTH);
  localparam logic [FLAT_W-1:0] KEEP = {FLAT_W{1'b1}} >> (FLAT_W - DATA_W);

  logic [MAX_ADDR_W+4:0]              beat_idx;
  logic [MAX_ADDR_W+4:0]              word_idx;
  logic [SLOT_W-1:0]                  slot;
  logic [BEATS-1:0][TOP_WIDTH-1:0]    shadow;
  logic [BEATS-1:0][TOP_WIDTH-1:0]    merged;
  logic [FLAT_W-1:0]                  merged_flat;
  logic [BEATS-1:0]                   mask;
  logic [BEATS-1:0]                   mask_hit;
  logic [MAX_DATA_W-1:0]              word_next;
  logic                               accept;
  logic                               oob;
  logic                               final_beat;
  logic                               load_done_q;

  assign beat_idx = addr >> 2;
  assign word_idx = beat_idx >> LOG_B;

  generate
    if (LOG_B == 0) begin : g_single
      assign slot = '0;
    end else begin : g_multi
      assign slot = beat_idx[LOG_B-1:0];
    end
  endgenerate

  assign accept     = en & we;
  assign oob        = (word_idx >= DEPTH_V);
  assign final_beat = (slot == SLOT_W'(BEATS - 1));

  // Shadow and mask as they would look with the current beat merged in;
  // the final beat is written straight from here without a shadow round-trip.
  always_comb begin
    merged   = shadow;
    mask_hit = mask;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (slot == SLOT_W'(i)) begin
        merged[i]   = din;
        mask_hit[i] = 1'b1;
      end
    end
  end

  assign merged_flat = merged;
  assign word_next   = MAX_DATA_W'(merged_flat & KEEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      shadow      <= '0;
      mask        <= '0;
      done        <= 1'b0;
      err_oob     <= 1'b0;
      err_partial <= 1'b0;
      word_count  <= '0;
      load_done_q <= 1'b0;
    end else if (soft_clr) begin
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      shadow      <= '0;
      mask        <= '0;
      done        <= 1'b0;
      err_oob     <= 1'b0;
      err_partial <= 1'b0;
      word_count  <= '0;
      // track the level so a load_done held through the clear is not an edge
      load_done_q <= load_done;
    end else begin
      bram_we     <= 1'b0;
      load_done_q <= load_done;
      if (accept) begin
        if (oob) begin
          err_oob <= 1'b1;
        end else begin
          shadow <= merged;
          if (final_beat) begin
            bram_we   <= 1'b1;
            bram_addr <= word_idx[MAX_ADDR_W-1:0];
            bram_din  <= word_next;
            mask      <= '0;
            if (word_count != '1) word_count <= word_count + 1'b1;
            if (!(&mask_hit)) err_partial <= 1'b1;
          end else begin
            mask <= mask_hit;
          end
        end
      end
      if (load_done && !load_done_q) begin
        done <= 1'b1;
        if (|mask) err_partial <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gat_host_bram_bridge.sv
// Host-to-accelerator BRAM bridge for the GAT core.
// Instantiates one beat packer per load channel, muxes per-channel status,
// generates a one-shot core start once every channel reports done, and
// provides a latency-matched feature readback path.
// Ports:
//   clk, rst, soft_clr                 clock, async reset, synchronous clear
//   host_din/en/we/addr, load_done     per-channel host load interface
//   bram_we/bram_addr/bram_din         per-channel core BRAM write port
//   rd_en, rd_addr, rd_dout, rd_valid  host readback
//   core_rd_addr, core_rd_dout         core feature BRAM read port
//   status_sel, status_word            selected channel status
//   all_done, gat_start                completion level and start pulse
module gat_host_bram_bridge
  import gat_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TOP_WIDTH  = 32,
  parameter int unsigned MAX_DATA_W = 128,
  parameter int unsigned MAX_ADDR_W = 18,
  parameter logic [NUM_CH*32-1:0] CH_DATA_W = {32'd8, 32'd19, 32'd21, 32'd16},
  parameter logic [NUM_CH*32-1:0] CH_DEPTH  = {32'd13264, 32'd13264, 32'd22928, 32'd242101},
  parameter int unsigned RD_DATA_W  = 32,
  parameter int unsigned RD_ADDR_W  = 16,
  parameter int unsigned RD_LAT     = 2,
  localparam int unsigned SEL_W     = (NUM_CH > 1) ? log2_f(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             soft_clr,
  input  logic [NUM_CH*TOP_WIDTH-1:0]      host_din,
  input  logic [NUM_CH-1:0]                host_en,
  input  logic [NUM_CH-1:0]                host_we,
  input  logic [NUM_CH*(MAX_ADDR_W+5)-1:0] host_addr,
  input  logic [NUM_CH-1:0]                load_done,
  output logic [NUM_CH-1:0]                bram_we,
  output logic [NUM_CH*MAX_ADDR_W-1:0]     bram_addr,
  output logic [NUM_CH*MAX_DATA_W-1:0]     bram_din,
  input  logic                             rd_en,
  input  logic [RD_ADDR_W+1:0]             rd_addr,
  output logic [RD_ADDR_W-1:0]             core_rd_addr,
  input  logic [RD_DATA_W-1:0]             core_rd_dout,
  output logic [RD_DATA_W-1:0]             rd_dout,
  output logic                             rd_valid,
  input  logic [SEL_W-1:0]                 status_sel,
  output logic [31:0]                      status_word,
  output logic                             all_done,
  output logic                             gat_start
);

  logic [NUM_CH-1:0]     done_v;
  logic [NUM_CH-1:0]     oob_v;
  logic [NUM_CH-1:0]     part_v;
  logic [ST_COUNT_W-1:0] cnt_v [NUM_CH];
  logic                  started;
  logic [RD_LAT-1:0]     vpipe;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_bram_beat_packer #(
      .TOP_WIDTH  (TOP_WIDTH),
      .MAX_DATA_W (MAX_DATA_W),
      .MAX_ADDR_W (MAX_ADDR_W),
      .DATA_W     (int'(CH_DATA_W[c*32 +: 32])),
      .DEPTH      (int'(CH_DEPTH[c*32 +: 32]))
    ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .soft_clr    (soft_clr),
      .din         (host_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .en          (host_en[c]),
      .we          (host_we[c]),
      .addr        (host_addr[c*(MAX_ADDR_W+5) +: (MAX_ADDR_W+5)]),
      .load_done   (load_done[c]),
      .bram_we     (bram_we[c]),
      .bram_addr   (bram_addr[c*MAX_ADDR_W +: MAX_ADDR_W]),
      .bram_din    (bram_din[c*MAX_DATA_W +: MAX_DATA_W]),
      .done        (done_v[c]),
      .err_oob     (oob_v[c]),
      .err_partial (part_v[c]),
      .word_count  (cnt_v[c])
    );
  end

  always_comb begin
    status_word = '0;
    if (32'(status_sel) < NUM_CH) begin
      status_word[ST_COUNT_W-1:0]  = cnt_v[status_sel];
      status_word[ST_DONE_BIT]     = done_v[status_sel];
      status_word[ST_PARTIAL_BIT]  = part_v[status_sel];
      status_word[ST_OOB_BIT]      = oob_v[status_sel];
    end
  end

  assign all_done = &done_v;

  // done bits are sticky, so all_done can only rise once per clear epoch;
  // 'started' still guards against a re-fire on the held level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started   <= 1'b0;
      gat_start <= 1'b0;
    end else if (soft_clr) begin
      started   <= 1'b0;
      gat_start <= 1'b0;
    end else begin
      gat_start <= all_done & ~started;
      started   <= started | all_done;
    end
  end

  assign core_rd_addr = RD_ADDR_W'(rd_addr >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe    <= '0;
      rd_valid <= 1'b0;
      rd_dout  <= '0;
    end else if (soft_clr) begin
      vpipe    <= '0;
      rd_valid <= 1'b0;
      rd_dout  <= '0;
    end else begin
      vpipe    <= RD_LAT'({vpipe, rd_en});
      rd_valid <= vpipe[RD_LAT-1];
      if (vpipe[RD_LAT-1]) rd_dout <= core_rd_dout;
    end
  end

endmodule

// File: tb/tb_gat_host_bram_bridge.sv
// Directed self-checking bench for gat_host_bram_bridge.
// Channel widths are overridden to 8/64/128/16 bits (BEATS 1/2/4/1) with
// depths 64/16/8/100 so every packing case and the OOB bound are reachable.
module tb_gat_host_bram_bridge;

  localparam int unsigned AW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          soft_clr;
  logic [127:0]  host_din;
  logic [3:0]    host_en;
  logic [3:0]    host_we;
  logic [91:0]   host_addr;
  logic [3:0]    load_done;
  logic [3:0]    bram_we;
  logic [71:0]   bram_addr;
  logic [511:0]  bram_din;
  logic          rd_en;
  logic [17:0]   rd_addr;
  logic [15:0]   core_rd_addr;
  logic [31:0]   core_rd_dout;
  logic [31:0]   rd_dout;
  logic          rd_valid;
  logic [1:0]    status_sel;
  logic [31:0]   status_word;
  logic          all_done;
  logic          gat_start;
  logic [31:0]   mem_q1;

  int checks = 0;
  int errors = 0;

  gat_host_bram_bridge #(
    .NUM_CH    (4),
    .CH_DATA_W ({32'd16, 32'd128, 32'd64, 32'd8}),
    .CH_DEPTH  ({32'd100, 32'd8, 32'd16, 32'd64}),
    .RD_LAT    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_clr     (soft_clr),
    .host_din     (host_din),
    .host_en      (host_en),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .load_done    (load_done),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .core_rd_addr (core_rd_addr),
    .core_rd_dout (core_rd_dout),
    .rd_dout      (rd_dout),
    .rd_valid     (rd_valid),
    .status_sel   (status_sel),
    .status_word  (status_word),
    .all_done     (all_done),
    .gat_start    (gat_start)
  );

  always #5 clk = ~clk;

  // Feature BRAM stub with two cycles of read latency; word n holds 0xD000_00nn
  always @(posedge clk) begin
    mem_q1       <= {16'hD000, core_rd_addr};
    core_rd_dout <= mem_q1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic beat(input int ch, input logic [AW-1:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    host_addr[ch*AW +: AW] = a;
    host_din[ch*32 +: 32]  = d;
    host_en[ch]            = 1'b1;
    host_we[ch]            = w;
    @(posedge clk);
    #1;
    host_en = '0;
    host_we = '0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    soft_clr = 1'b1;
    @(posedge clk);
    #1;
    soft_clr = 1'b0;
  endtask

  task automatic status(input string tag, input logic [1:0] ch, input logic [31:0] exp);
    status_sel = ch;
    #1;
    chk(tag, status_word, exp);
  endtask

  initial begin
    rst        = 1'b1;
    soft_clr   = 1'b0;
    host_din   = '0;
    host_en    = '0;
    host_we    = '0;
    host_addr  = '0;
    load_done  = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    status_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_bram_we", bram_we, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_dout", rd_dout, 0);
    chk("rst_gat_start", gat_start, 0);
    chk("rst_all_done", all_done, 0);
    status("rst_status0", 2'd0, 32'h0);

    // Channel 0: 8-bit word, one beat per word
    beat(0, 23'h10, 32'hABCD_EF5A, 1'b1);
    chk("c0_we", bram_we, 4'b0001);
    chk("c0_addr", bram_addr[0 +: 18], 18'd4);
    chk("c0_din", bram_din[0 +: 128], 128'h5A);
    status("c0_count", 2'd0, 32'h0000_0001);
    @(posedge clk); #1;
    chk("c0_we_one_cycle", bram_we, 4'b0000);

    // Enable without write enable is ignored
    beat(0, 23'h14, 32'h1234_5678, 1'b0);
    chk("read_only_no_we", bram_we, 4'b0000);
    status("read_only_count", 2'd0, 32'h0000_0001);

    // soft_clr wins over a beat in the same cycle
    @(negedge clk);
    soft_clr = 1'b1;
    beat(0, 23'h18, 32'h0000_0077, 1'b1);
    soft_clr = 1'b0;
    chk("clr_prio_we", bram_we, 4'b0000);
    status("clr_prio_count", 2'd0, 32'h0);

    // Channel 1: 64-bit word from two beats
    beat(1, 23'h08, 32'h1111_1111, 1'b1);
    chk("c1_first_no_we", bram_we, 4'b0000);
    beat(1, 23'h0C, 32'h2222_2222, 1'b1);
    chk("c1_we", bram_we, 4'b0010);
    chk("c1_addr", bram_addr[18 +: 18], 18'd1);
    chk("c1_din", bram_din[128 +: 128], 128'h2222_2222_1111_1111);
    status("c1_status", 2'd1, 32'h0000_0001);

    // Final slot alone after clear: low half stays zero, partial flagged
    clear_pulse();
    beat(1, 23'h0C, 32'h3333_3333, 1'b1);
    chk("c1_partial_we", bram_we, 4'b0010);
    chk("c1_partial_din", bram_din[128 +: 128], 128'h3333_3333_0000_0000);
    status("c1_partial_status", 2'd1, 32'h4000_0001);

    // word_addr == depth (16): dropped, OOB set, count unchanged
    beat(1, 23'h80, 32'hDEAD_BEEF, 1'b1);
    chk("c1_oob_no_we", bram_we, 4'b0000);
    status("c1_oob_status", 2'd1, 32'hC000_0001);

    // Channel 2: 128-bit word from four beats, slot order check
    beat(2, 23'h20, 32'hAAAA_0000, 1'b1);
    beat(2, 23'h24, 32'hBBBB_1111, 1'b1);
    beat(2, 23'h28, 32'hCCCC_2222, 1'b1);
    chk("c2_third_no_we", bram_we, 4'b0000);
    beat(2, 23'h2C, 32'hDDDD_3333, 1'b1);
    chk("c2_we", bram_we, 4'b0100);
    chk("c2_addr", bram_addr[36 +: 18], 18'd2);
    chk("c2_din", bram_din[256 +: 128], 128'hDDDD_3333_CCCC_2222_BBBB_1111_AAAA_0000);

    // Channel 3: 16-bit word, upper host bits discarded
    beat(3, 23'h04, 32'h1234_ABCD, 1'b1);
    chk("c3_we", bram_we, 4'b1000);
    chk("c3_addr", bram_addr[54 +: 18], 18'd1);
    chk("c3_din", bram_din[384 +: 128], 128'hABCD);

    // load_done edge while a word is half built flags partial
    clear_pulse();
    beat(2, 23'h20, 32'h0000_0001, 1'b1);
    @(negedge clk);
    load_done = 4'b0100;
    @(posedge clk); #1;
    status("c2_done_partial", 2'd2, 32'h6000_0000);
    chk("c2_not_all_done", all_done, 0);
    @(negedge clk);
    load_done = 4'b0000;
    clear_pulse();

    // Start generation: bits rise in order 3,0,2,1
    @(negedge clk); load_done[3] = 1'b1;
    @(posedge clk); #1;
    chk("start_after3_all_done", all_done, 0);
    status("c3_done", 2'd3, 32'h2000_0000);
    @(negedge clk); load_done[0] = 1'b1;
    @(negedge clk); load_done[2] = 1'b1;
    @(negedge clk); load_done[1] = 1'b1;
    @(posedge clk); #1;
    chk("start_all_done", all_done, 1);
    chk("start_not_yet", gat_start, 0);
    @(posedge clk); #1;
    chk("start_pulse", gat_start, 1);
    @(posedge clk); #1;
    chk("start_one_cycle", gat_start, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("start_no_retrigger", gat_start, 0);
    @(negedge clk); load_done = 4'b0000;
    clear_pulse();
    chk("start_clr_all_done", all_done, 0);
    @(negedge clk); load_done = 4'b1111;
    @(posedge clk); #1;
    chk("start2_all_done", all_done, 1);
    chk("start2_not_yet", gat_start, 0);
    @(posedge clk); #1;
    chk("start2_pulse", gat_start, 1);
    @(negedge clk); load_done = 4'b0000;
    clear_pulse();

    // Readback: three back-to-back requests at 0, 4, 8
    @(negedge clk); rd_en = 1'b1; rd_addr = 18'h0;
    @(posedge clk); #1;
    chk("rd_c1_invalid", rd_valid, 0);
    @(negedge clk); rd_addr = 18'h4;
    @(posedge clk); #1;
    chk("rd_c2_invalid", rd_valid, 0);
    @(negedge clk); rd_addr = 18'h8;
    #1;
    chk("rd_core_addr", core_rd_addr, 16'd2);
    @(posedge clk); #1;
    chk("rd_c3_valid", rd_valid, 1);
    chk("rd_c3_data", rd_dout, 32'hD000_0000);
    @(negedge clk); rd_en = 1'b0;
    @(posedge clk); #1;
    chk("rd_c4_valid", rd_valid, 1);
    chk("rd_c4_data", rd_dout, 32'hD000_0001);
    @(posedge clk); #1;
    chk("rd_c5_valid", rd_valid, 1);
    chk("rd_c5_data", rd_dout, 32'hD000_0002);
    @(posedge clk); #1;
    chk("rd_idle_valid", rd_valid, 0);
    chk("rd_idle_hold", rd_dout, 32'hD000_0002);

    // Half-built word on channel 1, then reset during a readback burst
    beat(1, 23'h08, 32'h5555_5555, 1'b1);
    @(negedge clk); rd_en = 1'b1; rd_addr = 18'h0;
    @(negedge clk); rd_addr = 18'h4;
    @(negedge clk); rd_addr = 18'h8;
    @(negedge clk); rd_en = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_valid_before", rd_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid_drop", rd_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_no_we", bram_we, 4'b0000);
    status("rst_mid_status", 2'd1, 32'h0);
    beat(1, 23'h0C, 32'h6666_6666, 1'b1);
    chk("rst_mid_din", bram_din[128 +: 128], 128'h6666_6666_0000_0000);
    status("rst_mid_partial", 2'd1, 32'h4000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
